// File: rtl/fetch_pkg.sv
// Shared types for the fetch-stage controller: FSM states, redirect kinds
// and the pending-redirect record held while instruction memory is busy.
package fetch_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        PEND  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        JMP  = 2'd2
    } redir_kind_t;

    typedef struct packed {
        redir_kind_t           kind;
        logic [XLEN_DEF-1:0]   operand;
    } pend_redir_t;

    function automatic pend_redir_t pend_clear();
        pend_redir_t p;
        p.kind    = NONE;
        p.operand = '0;
        return p;
    endfunction

    function automatic pend_redir_t pend_make(input redir_kind_t kind,
                                              input logic [XLEN_DEF-1:0] operand);
        pend_redir_t p;
        p.kind    = kind;
        p.operand = operand;
        return p;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Stall/redirect performance counters for fetch_ctrl; built only when
// FETCH_CTRL_PERF_EN is defined. Counters wrap modulo 2^CNT_W.
`ifdef FETCH_CTRL_PERF_EN
module fetch_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_mwait,
    input  logic             inc_stall,
    input  logic             inc_redir,
    output logic [CNT_W-1:0] cnt_mwait,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_redir
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_mwait <= '0;
            cnt_stall <= '0;
            cnt_redir <= '0;
        end else begin
            if (inc_mwait) cnt_mwait <= cnt_mwait + CNT_W'(1);
            if (inc_stall) cnt_stall <= cnt_stall + CNT_W'(1);
            if (inc_redir) cnt_redir <= cnt_redir + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: arbitrates branch/jump redirects, load-use stalls and
// imem wait states into PC-unit controls. Counters need FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ack,
    output logic             imem_req,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_offset,
    input  logic             jmp,
    input  logic [XLEN-1:0]  jmp_target,
    input  logic             ld_use_stall,
    output logic             holdPC,
    output logic             isBranch,
    output logic             PCsrc,
    output logic [XLEN-1:0]  PCoffset,
    output logic [XLEN-1:0]  jVal,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] cnt_mwait,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_redir
);

    fetch_state_t state;
    pend_redir_t  pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            pend  <= pend_clear();
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (!imem_ack && br_taken) begin
                        state <= PEND;
                        pend  <= pend_make(BR, XLEN_DEF'(br_offset));
                    end else if (!imem_ack && jmp) begin
                        state <= PEND;
                        pend  <= pend_make(JMP, XLEN_DEF'(jmp_target));
                    end
                end
                PEND: begin
                    if (imem_ack) begin
                        state <= FETCH;
                        pend  <= pend_clear();
                    end else if (br_taken) begin
                        // The branch is older than anything pending, so it always wins.
                        pend <= pend_make(BR, XLEN_DEF'(br_offset));
                    end
                end
                default: begin
                    state <= BOOT;
                    pend  <= pend_clear();
                end
            endcase
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        holdPC      = 1'b1;
        isBranch    = 1'b0;
        PCsrc       = 1'b0;
        PCoffset    = '0;
        jVal        = '0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (br_taken) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (imem_ack) begin
                        holdPC   = 1'b0;
                        isBranch = 1'b1;
                        PCoffset = br_offset;
                    end
                end else if (jmp) begin
                    flush_if_id = 1'b1;
                    if (imem_ack) begin
                        holdPC = 1'b0;
                        PCsrc  = 1'b1;
                        jVal   = jmp_target;
                    end
                end else if (ld_use_stall) begin
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (imem_ack) begin
                    holdPC = 1'b0;
                end else begin
                    stall_if_id = 1'b1;
                end
            end
            PEND: begin
                imem_req    = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = br_taken;
                // The word arriving with the ack belongs to the wrong path; it is flushed.
                if (imem_ack) begin
                    if (br_taken) begin
                        holdPC   = 1'b0;
                        isBranch = 1'b1;
                        PCoffset = br_offset;
                    end else if (pend.kind == BR) begin
                        holdPC   = 1'b0;
                        isBranch = 1'b1;
                        PCoffset = XLEN'(pend.operand);
                    end else if (pend.kind == JMP) begin
                        holdPC = 1'b0;
                        PCsrc  = 1'b1;
                        jVal   = XLEN'(pend.operand);
                    end
                end
            end
            default: begin
                imem_req = 1'b0;
                holdPC   = 1'b1;
            end
        endcase
    end

`ifdef FETCH_CTRL_PERF_EN
    logic inc_mwait;
    logic inc_stall;
    logic inc_redir;

    assign inc_mwait = imem_req && !imem_ack;
    assign inc_stall = (state == FETCH) && ld_use_stall && !br_taken && !jmp;
    assign inc_redir = !holdPC && (isBranch || PCsrc);

    fetch_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .inc_mwait (inc_mwait),
        .inc_stall (inc_stall),
        .inc_redir (inc_redir),
        .cnt_mwait (cnt_mwait),
        .cnt_stall (cnt_stall),
        .cnt_redir (cnt_redir)
    );
`else
    assign cnt_mwait = '0;
    assign cnt_stall = '0;
    assign cnt_redir = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model queues the expected
// outputs for each driven cycle and a negedge monitor compares them.
module tb_fetch_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             imem_ack = 1'b0;
    logic             imem_req;
    logic             br_taken = 1'b0;
    logic [XLEN-1:0]  br_offset = '0;
    logic             jmp = 1'b0;
    logic [XLEN-1:0]  jmp_target = '0;
    logic             ld_use_stall = 1'b0;
    logic             holdPC, isBranch, PCsrc;
    logic [XLEN-1:0]  PCoffset, jVal;
    logic             stall_if_id, flush_if_id, flush_id_ex;
    logic [CNT_W-1:0] cnt_mwait, cnt_stall, cnt_redir;

    fetch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_ack     (imem_ack),
        .imem_req     (imem_req),
        .br_taken     (br_taken),
        .br_offset    (br_offset),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .ld_use_stall (ld_use_stall),
        .holdPC       (holdPC),
        .isBranch     (isBranch),
        .PCsrc        (PCsrc),
        .PCoffset     (PCoffset),
        .jVal         (jVal),
        .stall_if_id  (stall_if_id),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .cnt_mwait    (cnt_mwait),
        .cnt_stall    (cnt_stall),
        .cnt_redir    (cnt_redir)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req, hold, isb, pcs;
        logic [31:0] off, jv;
        logic        stl, fif, fie;
        logic [31:0] cm, cs, cr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("imem_req",    64'(imem_req),    64'(e.req));
            check("holdPC",      64'(holdPC),      64'(e.hold));
            check("isBranch",    64'(isBranch),    64'(e.isb));
            check("PCsrc",       64'(PCsrc),       64'(e.pcs));
            check("PCoffset",    64'(PCoffset),    64'(e.off));
            check("jVal",        64'(jVal),        64'(e.jv));
            check("stall_if_id", 64'(stall_if_id), 64'(e.stl));
            check("flush_if_id", 64'(flush_if_id), 64'(e.fif));
            check("flush_id_ex", 64'(flush_id_ex), 64'(e.fie));
            check("cnt_mwait",   64'(cnt_mwait),   64'(e.cm));
            check("cnt_stall",   64'(cnt_stall),   64'(e.cs));
            check("cnt_redir",   64'(cnt_redir),   64'(e.cr));
            check("br_jmp_excl", 64'(isBranch & PCsrc), 64'(0));
        end
    end

    // Reference model: 0=BOOT 1=FETCH 2=PEND; kind 0=none 1=branch 2=jump
    int          m_st = 0;
    int          m_kind = 0;
    logic [31:0] m_op = '0;
    logic [31:0] m_cm = '0, m_cs = '0, m_cr = '0;

    task automatic cyc(input logic r, input logic b, input logic [31:0] bo,
                       input logic j, input logic [31:0] jt, input logic ld, input logic ak);
        exp_t        e;
        int          n_st, n_kind;
        logic [31:0] n_op;
        logic        i_mw, i_st, i_rd;
        rst = r; br_taken = b; br_offset = bo; jmp = j; jmp_target = jt;
        ld_use_stall = ld; imem_ack = ak;
        if (!r) begin
            m_st = 0; m_kind = 0; m_op = '0; m_cm = '0; m_cs = '0; m_cr = '0;
        end
        e = '0;
        e.hold = 1'b1;
        n_st = m_st; n_kind = m_kind; n_op = m_op;
        i_mw = 1'b0; i_st = 1'b0; i_rd = 1'b0;
        if (r) begin
            if (m_st == 0) begin
                n_st = 1;
            end else if (m_st == 1) begin
                e.req = 1'b1;
                i_mw  = !ak;
                if (b) begin
                    e.fif = 1'b1; e.fie = 1'b1;
                    if (ak) begin e.hold = 1'b0; e.isb = 1'b1; e.off = bo; i_rd = 1'b1; end
                    else    begin n_st = 2; n_kind = 1; n_op = bo; end
                end else if (j) begin
                    e.fif = 1'b1;
                    if (ak) begin e.hold = 1'b0; e.pcs = 1'b1; e.jv = jt; i_rd = 1'b1; end
                    else    begin n_st = 2; n_kind = 2; n_op = jt; end
                end else if (ld) begin
                    e.stl = 1'b1; e.fie = 1'b1; i_st = 1'b1;
                end else begin
                    e.hold = !ak; e.stl = !ak;
                end
            end else begin
                e.req = 1'b1; e.fif = 1'b1; e.fie = b;
                i_mw  = !ak;
                if (ak) begin
                    e.hold = 1'b0; i_rd = 1'b1;
                    if (b)                begin e.isb = 1'b1; e.off = bo; end
                    else if (m_kind == 1) begin e.isb = 1'b1; e.off = m_op; end
                    else                  begin e.pcs = 1'b1; e.jv = m_op; end
                    n_st = 1; n_kind = 0; n_op = '0;
                end else if (b) begin
                    n_kind = 1; n_op = bo;
                end
            end
        end
`ifdef FETCH_CTRL_PERF_EN
        e.cm = m_cm; e.cs = m_cs; e.cr = m_cr;
`endif
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            m_st = n_st; m_kind = n_kind; m_op = n_op;
            m_cm = m_cm + 32'(i_mw); m_cs = m_cs + 32'(i_st); m_cr = m_cr + 32'(i_rd);
        end
        #1;
    endtask

    task automatic idle(input logic ak);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ak);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset and release with ack high: BOOT first, then sequential fetch
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        // Zero-wait branch, then a plain wait cycle
        cyc(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b0);
        // Jump during three wait cycles
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Branch overwrites pending jump
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b1);
        // Load-use alone, while waiting, then against a branch
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b1);
        // New branch together with the ack in PEND
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 1'b1);
        // Branch replaces pending branch
        cyc(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'hC, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b1);
        // Reset while pending: redirect dropped
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 3) == 0), $urandom,
                ($urandom_range(0, 3) == 0), $urandom,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) < 6));
        end
        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the pipelined core. Generates the PC unit's `holdPC`, `PCsrc`, `isBranch`, `PCoffset` and `jVal` controls, and drives the instruction-memory request handshake. Arbitrates between EX-stage branch redirects, ID-stage jumps, ID load-use stalls and memory wait states, and raises the IF/ID and ID/EX flush and stall signals. It sits between the hazard sources and the PC / IF/ID registers.

## Interface
- `XLEN`, 32, width of the PC, offset and jump target.
- `CNT_W`, 32, width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_ack` in 1: instruction word valid this cycle for the current PC.
- `imem_req` out 1: fetch request for the current PC.
- `br_taken` in 1: EX-stage branch resolved taken.
- `br_offset` in XLEN: branch offset, added to the PC.
- `jmp` in 1: ID-stage jump decoded.
- `jmp_target` in XLEN: absolute jump target.
- `ld_use_stall` in 1: ID-stage load-use hazard.
- `holdPC`, `isBranch`, `PCsrc` out 1: PC unit controls.
- `PCoffset`, `jVal` out XLEN: PC unit operands.
- `stall_if_id` out 1: IF/ID register holds its value.
- `flush_if_id`, `flush_id_ex` out 1: insert a bubble.
- `cnt_mwait`, `cnt_stall`, `cnt_redir` out CNT_W: performance counters.

## Operation
- FSM states: BOOT, FETCH, PEND.
- **BOOT**
  - Entered on reset. Exits to FETCH on the first clock edge after `rst` deasserts.
  - Outputs: `imem_req`=0, `holdPC`=1.
- **FETCH**
  - `imem_req`=1.
  - Request priority, highest first: `br_taken` > `jmp` > `ld_use_stall` > memory wait > sequential.
- **FETCH, `br_taken`**
  - Always: `flush_if_id`=1 and `flush_id_ex`=1 this cycle.
  - With `imem_ack`=1: `holdPC`=0, `isBranch`=1, `PCoffset`=`br_offset`. Stay in FETCH.
  - With `imem_ack`=0: latch kind=BR and the offset into the pending register. `holdPC`=1. Go to PEND.
- **FETCH, `jmp`** (no branch)
  - Always: `flush_if_id`=1. `flush_id_ex`=0.
  - With `imem_ack`=1: `holdPC`=0, `PCsrc`=1, `jVal`=`jmp_target`.
  - With `imem_ack`=0: latch kind=JMP and the target. Go to PEND.
- **FETCH, `ld_use_stall`** (no redirect)
  - `holdPC`=1, `stall_if_id`=1, `flush_id_ex`=1, regardless of `imem_ack`.
  - The same PC is refetched.
- **FETCH, no request**
  - With `imem_ack`=0: `holdPC`=1 and `stall_if_id`=1.
  - With `imem_ack`=1: `holdPC`=0 (PC+4).
- **PEND**
  - `imem_req`=1, `holdPC`=1, `flush_if_id`=1.
  - A new `br_taken` overwrites a pending JMP (the branch is older) and asserts `flush_id_ex`.
  - A new `br_taken` replaces a pending BR.
  - `jmp` and `ld_use_stall` are ignored in PEND.
  - On `imem_ack`=1: the fetched word is discarded via `flush_if_id`. Apply the pending redirect (`holdPC`=0, `isBranch` or `PCsrc` from kind, operand from the register) and return to FETCH.
  - If `br_taken` and `imem_ack` occur in the same cycle, the new branch is applied directly.
- `isBranch` and `PCsrc` are never high together. When `holdPC`=0 and no redirect, both are 0.
- `PCoffset` and `jVal` read 0 when not in use.

## Timing
- All outputs except the counters are combinational from state, pending register and inputs. The PC updates at the edge ending the cycle.
- Redirect latency:
  - 0 cycles when `imem_ack`=1.
  - Otherwise, applied in the `imem_ack` cycle.
- Reset values:
  - state=BOOT, pending kind=NONE, pending operand=0, counters=0.
  - `imem_req`=0, `holdPC`=1, all other outputs 0.
- Asserting `rst` mid-PEND drops the pending redirect immediately.
- `imem_ack` while `imem_req`=0 is ignored.

## Configuration
- Macro: `FETCH_CTRL_PERF_EN`.
- **Defined:**
  - `cnt_mwait` increments on each `imem_req` cycle with `imem_ack`=0.
  - `cnt_stall` increments on each cycle an applied `ld_use_stall` is honoured.
  - `cnt_redir` increments on each applied redirect.
  - All three wrap modulo 2^CNT_W.
- **Undefined:** the counter ports stay present and are tied to 0. No counter registers are built.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` (BOOT, FETCH, PEND).
  - `redir_kind_t` (NONE, BR, JMP).
  - Pending-redirect struct {kind, operand}.
  - `XLEN_DEF`.
- Sub-module `fetch_perf_cnt`: the three counters, under the macro.

## Test plan
- **Reset release:** `rst` low→high with `imem_ack`=1.
  - Cycle 1: BOOT, `holdPC`=1, `imem_req`=0.
  - Cycle 2: `imem_req`=1, `holdPC`=0.
- **Zero-wait branch:** `br_taken`=1, `br_offset`=0x10, `imem_ack`=1.
  - `isBranch`=1, `PCoffset`=0x10, both flushes high, state stays FETCH.
- **Jump during wait:** `jmp`=1, `jmp_target`=0x40 with `imem_ack`=0 for 3 cycles, then 1.
  - PEND for 3 cycles with `holdPC`=1.
  - Then `PCsrc`=1, `jVal`=0x40, `flush_if_id`=1.
  - `cnt_mwait`=3 with the macro.
- **Branch over pending jump:** in PEND holding JMP 0x40, `br_taken`=1, `br_offset`=0x8, then ack.
  - `isBranch`=1, `PCoffset`=0x8, `PCsrc`=0.
- **Load-use vs branch:** `ld_use_stall`=1 alone gives `holdPC`=1, `stall_if_id`=1, `flush_id_ex`=1. With `br_taken`=1 added, the branch wins.
- **Reset in PEND:** `rst`=0 while PEND, then release.
  - Back to BOOT, pending kind NONE.
  - No redirect is applied on the next ack.
